// File: rtl/ifid_pkg.sv
// IF/ID shared definitions: squash FSM states,
// default NOP encoding and decode field positions.
package ifid_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    CALL_SQ  = 2'd1,
    RET_WAIT = 2'd2
  } ifid_state_e;

  localparam logic [15:0] IFID_NOP = 16'hF000;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 8;
  localparam int BR_HI  = 10;
  localparam int BR_LO  = 8;
  localparam int RS_HI  = 7;
  localparam int RS_LO  = 4;
  localparam int RT_HI  = 3;
  localparam int RT_LO  = 0;

endpackage

// File: rtl/ifid_squash_fsm.sv
// IF/ID squash controller: RUN / CALL_SQ / RET_WAIT state,
// call bubble counter, field load enable and NOP inject/capture.
module ifid_squash_fsm
  import ifid_pkg::*;
#(
  parameter int CALL_BUBBLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic data_hazard,
  input  logic PC_hazard,
  input  logic call,
  input  logic ret_control,
  input  logic ret_PC,
  output logic load_en,
  output logic inject_nop,
  output logic capture,
  output logic squashing
);

  localparam logic [3:0] CNT_INIT = 4'(CALL_BUBBLES - 1);
  localparam bit MULTI = (CALL_BUBBLES > 1);

  ifid_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  // One-hot view of the RUN priority chain
  logic do_call, do_flush, do_ret, do_hold, do_load;

  always_comb begin
    do_call  = call;
    do_flush = !call && PC_hazard;
    do_ret   = !call && !PC_hazard && ret_control;
    do_hold  = !call && !PC_hazard && !ret_control
               && data_hazard;
    do_load  = !call && !PC_hazard && !ret_control
               && !data_hazard;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load_en    = 1'b0;
    inject_nop = 1'b0;
    capture    = 1'b0;
    unique case (state_q)
      RUN: begin
        load_en = !data_hazard && !call && !ret_control;
        unique case (1'b1)
          do_call: begin
            inject_nop = 1'b1;
            if (MULTI) begin
              state_d = CALL_SQ;
              cnt_d   = CNT_INIT;
            end
          end
          do_flush: inject_nop = 1'b1;
          do_ret: begin
            inject_nop = 1'b1;
            state_d    = RET_WAIT;
          end
          do_hold: capture = 1'b0;
          do_load: capture = 1'b1;
          default: capture = 1'b0;
        endcase
      end
      CALL_SQ: begin
        inject_nop = 1'b1;
        cnt_d      = cnt_q - 4'd1;
        // <= guards against a stray zero count
        if (cnt_q <= 4'd1) begin
          state_d = RUN;
          cnt_d   = 4'd0;
        end
      end
      RET_WAIT: begin
        inject_nop = 1'b1;
        if (ret_PC) state_d = RUN;
      end
      default: begin
        state_d = RUN;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign squashing = (state_q != RUN);

endmodule

// File: rtl/ifid_pipe_reg_p.sv
// IF/ID pipeline register: instruction/valid register, field
// register with decode slices, squash FSM and stall counter.
module ifid_pipe_reg_p
  import ifid_pkg::*;
#(
  parameter int          PC_W         = 16,
  parameter logic [15:0] NOP_INSTR    = IFID_NOP,
  parameter int          CALL_BUBBLES = 1,
  parameter int          PERF_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_hazard,
  input  logic              PC_hazard,
  input  logic              call,
  input  logic              ret_control,
  input  logic              ret_PC,
  input  logic [15:0]       instruction_in,
  input  logic [PC_W-1:0]   PC_in,
  output logic [15:0]       instruction_out,
  output logic [PC_W-1:0]   PC_out,
  output logic              valid_out,
  output logic [3:0]        cntrl_input,
  output logic [3:0]        reg_rd,
  output logic [2:0]        branch_cond,
  output logic [3:0]        reg_rs,
  output logic [3:0]        reg_rt,
  output logic [3:0]        arith_imm,
  output logic [7:0]        load_save_imm,
  output logic [11:0]       call_target,
  output logic              squashing,
  output logic [PERF_W-1:0] stall_cycles
);

  logic load_en, inject_nop, capture;

  ifid_squash_fsm #(
    .CALL_BUBBLES(CALL_BUBBLES)
  ) u_fsm (
    .clk        (clk),
    .rst        (rst),
    .data_hazard(data_hazard),
    .PC_hazard  (PC_hazard),
    .call       (call),
    .ret_control(ret_control),
    .ret_PC     (ret_PC),
    .load_en    (load_en),
    .inject_nop (inject_nop),
    .capture    (capture),
    .squashing  (squashing)
  );

  logic [15:0]       ins_q, ins_d;
  logic              valid_q, valid_d;
  logic [15:0]       fld_q, fld_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PERF_W-1:0] stall_q, stall_d;

  always_comb begin
    ins_d   = ins_q;
    valid_d = valid_q;
    if (inject_nop) begin
      ins_d   = NOP_INSTR;
      valid_d = 1'b0;
    end else if (capture) begin
      ins_d   = instruction_in;
      valid_d = 1'b1;
    end
  end

  always_comb begin
    fld_d = fld_q;
    pc_d  = pc_q;
    if (load_en) begin
      fld_d = instruction_in;
      pc_d  = PC_in;
    end
  end

  // Saturates at all-ones
  always_comb begin
    stall_d = stall_q;
    if (data_hazard && !(&stall_q))
      stall_d = stall_q + PERF_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ins_q   <= NOP_INSTR;
      valid_q <= 1'b0;
      fld_q   <= 16'd0;
      pc_q    <= '0;
      stall_q <= '0;
    end else begin
      ins_q   <= ins_d;
      valid_q <= valid_d;
      fld_q   <= fld_d;
      pc_q    <= pc_d;
      stall_q <= stall_d;
    end
  end

  assign instruction_out = ins_q;
  assign valid_out       = valid_q;
  assign PC_out          = pc_q;
  assign stall_cycles    = stall_q;

  assign cntrl_input   = fld_q[OPC_HI:OPC_LO];
  assign reg_rd        = fld_q[RD_HI:RD_LO];
  assign branch_cond   = fld_q[BR_HI:BR_LO];
  assign reg_rs        = fld_q[RS_HI:RS_LO];
  assign reg_rt        = fld_q[RT_HI:RT_LO];
  assign arith_imm     = fld_q[RT_HI:RT_LO];
  assign load_save_imm = fld_q[RS_HI:RT_LO];
  assign call_target   = fld_q[RD_HI:RT_LO];

endmodule

// File: tb/tb_ifid_pipe_reg_p.sv
// Bench for ifid_pipe_reg_p: two instances (3 bubbles/2-bit
// perf, 1 bubble/16-bit perf) against a cycle model.
module tb_ifid_pipe_reg_p;

  logic clk = 1'b0;
  logic rst;
  logic dh, pch, cl, rc, rp;
  logic [15:0] ins, pc;

  logic [15:0] o_ins[2];
  logic        o_val[2];
  logic [15:0] o_pc[2];
  logic [3:0]  o_cn[2], o_rd[2], o_rs[2], o_rt[2], o_ai[2];
  logic [2:0]  o_br[2];
  logic [7:0]  o_ls[2];
  logic [11:0] o_ct[2];
  logic        o_sq[2];
  logic [1:0]  st_a;
  logic [15:0] st_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ifid_pipe_reg_p #(
    .PC_W(16), .NOP_INSTR(16'hF000),
    .CALL_BUBBLES(3), .PERF_W(2)
  ) u_a (
    .clk(clk), .rst(rst), .data_hazard(dh),
    .PC_hazard(pch), .call(cl), .ret_control(rc),
    .ret_PC(rp), .instruction_in(ins), .PC_in(pc),
    .instruction_out(o_ins[0]), .PC_out(o_pc[0]),
    .valid_out(o_val[0]), .cntrl_input(o_cn[0]),
    .reg_rd(o_rd[0]), .branch_cond(o_br[0]),
    .reg_rs(o_rs[0]), .reg_rt(o_rt[0]),
    .arith_imm(o_ai[0]), .load_save_imm(o_ls[0]),
    .call_target(o_ct[0]), .squashing(o_sq[0]),
    .stall_cycles(st_a)
  );

  ifid_pipe_reg_p #(
    .PC_W(16), .NOP_INSTR(16'hF000),
    .CALL_BUBBLES(1), .PERF_W(16)
  ) u_b (
    .clk(clk), .rst(rst), .data_hazard(dh),
    .PC_hazard(pch), .call(cl), .ret_control(rc),
    .ret_PC(rp), .instruction_in(ins), .PC_in(pc),
    .instruction_out(o_ins[1]), .PC_out(o_pc[1]),
    .valid_out(o_val[1]), .cntrl_input(o_cn[1]),
    .reg_rd(o_rd[1]), .branch_cond(o_br[1]),
    .reg_rs(o_rs[1]), .reg_rt(o_rt[1]),
    .arith_imm(o_ai[1]), .load_save_imm(o_ls[1]),
    .call_target(o_ct[1]), .squashing(o_sq[1]),
    .stall_cycles(st_b)
  );

  // Model: remaining forced-NOP cycles, return-wait flag
  int          bub[2]  = '{3, 1};
  int          smax[2] = '{3, 65535};
  int          m_left[2];
  bit          m_ret[2];
  logic [15:0] m_ins[2];
  bit          m_val[2];
  logic [15:0] m_fld[2];
  logic [15:0] m_pc[2];
  int          m_stall[2];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_left[i]  = 0;
      m_ret[i]   = 0;
      m_ins[i]   = 16'hF000;
      m_val[i]   = 0;
      m_fld[i]   = 0;
      m_pc[i]    = 0;
      m_stall[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      bit run;
      run = (m_left[i] == 0) && !m_ret[i];
      if (run && !dh && !cl && !rc) begin
        m_fld[i] = ins;
        m_pc[i]  = pc;
      end
      if (dh && m_stall[i] < smax[i]) m_stall[i]++;
      if (m_left[i] > 0) begin
        m_ins[i] = 16'hF000; m_val[i] = 0;
        m_left[i]--;
      end else if (m_ret[i]) begin
        m_ins[i] = 16'hF000; m_val[i] = 0;
        if (rp) m_ret[i] = 0;
      end else if (cl) begin
        m_ins[i] = 16'hF000; m_val[i] = 0;
        m_left[i] = bub[i] - 1;
      end else if (pch) begin
        m_ins[i] = 16'hF000; m_val[i] = 0;
      end else if (rc) begin
        m_ins[i] = 16'hF000; m_val[i] = 0;
        m_ret[i] = 1;
      end else if (!dh) begin
        m_ins[i] = ins; m_val[i] = 1;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      logic [15:0] f;
      logic [31:0] st;
      f  = m_fld[i];
      st = (i == 0) ? 32'(st_a) : 32'(st_b);
      check($sformatf("ins%0d", i), 32'(o_ins[i]), 32'(m_ins[i]));
      check($sformatf("val%0d", i), 32'(o_val[i]), 32'(m_val[i]));
      check($sformatf("pc%0d", i), 32'(o_pc[i]), 32'(m_pc[i]));
      check($sformatf("sq%0d", i), 32'(o_sq[i]),
            32'((m_left[i] > 0) || m_ret[i]));
      check($sformatf("stall%0d", i), st, 32'(m_stall[i]));
      check($sformatf("cn%0d", i), 32'(o_cn[i]), 32'(f / 4096));
      check($sformatf("rd%0d", i), 32'(o_rd[i]), 32'((f / 256) % 16));
      check($sformatf("br%0d", i), 32'(o_br[i]), 32'((f / 256) % 8));
      check($sformatf("rs%0d", i), 32'(o_rs[i]), 32'((f / 16) % 16));
      check($sformatf("rt%0d", i), 32'(o_rt[i]), 32'(f % 16));
      check($sformatf("ai%0d", i), 32'(o_ai[i]), 32'(f % 16));
      check($sformatf("ls%0d", i), 32'(o_ls[i]), 32'(f % 256));
      check($sformatf("ct%0d", i), 32'(o_ct[i]), 32'(f % 4096));
    end
  endtask

  task automatic step(input bit d, input bit p, input bit c,
                      input bit r, input bit q,
                      input logic [15:0] in_i,
                      input logic [15:0] in_p);
    dh = d; pch = p; cl = c; rc = r; rp = q;
    ins = in_i; pc = in_p;
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1;
    dh = 0; pch = 0; cl = 0; rc = 0; rp = 0;
    ins = 0; pc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    check("rst_ins", 32'(o_ins[0]), 32'hF000);
    rst = 1'b0;

    // Plain load
    step(0, 0, 0, 0, 0, 16'h1234, 16'h0010);
    check("t1_ins", 32'(o_ins[0]), 32'h1234);
    check("t1_pc", 32'(o_pc[0]), 32'h0010);
    check("t1_cn", 32'(o_cn[0]), 32'h1);
    check("t1_rd", 32'(o_rd[0]), 32'h2);
    check("t1_rs", 32'(o_rs[0]), 32'h3);
    check("t1_rt", 32'(o_rt[0]), 32'h4);

    // Stall holds
    step(1, 0, 0, 0, 0, 16'h5678, 16'h0012);
    step(1, 0, 0, 0, 0, 16'h5678, 16'h0012);
    check("t2_hold", 32'(o_ins[0]), 32'h1234);
    check("t2_val", 32'(o_val[0]), 32'h1);
    check("t2_stall", 32'(st_b), 32'd2);
    step(0, 0, 0, 0, 0, 16'h5678, 16'h0012);
    check("t2_ins", 32'(o_ins[0]), 32'h5678);

    // Call squash, 3 bubbles on u_a
    step(0, 0, 0, 0, 0, 16'hA0FF, 16'h0020);
    step(0, 0, 1, 0, 0, 16'h1111, 16'h0022);
    check("t3_nop1", 32'(o_ins[0]), 32'hF000);
    check("t3_sq1", 32'(o_sq[0]), 32'h1);
    step(0, 0, 0, 0, 0, 16'h2222, 16'h0024);
    check("t3_nop2", 32'(o_val[0]), 32'h0);
    check("t3_ct", 32'(o_ct[0]), 32'h0FF);
    step(0, 0, 0, 0, 0, 16'h3333, 16'h0026);
    check("t3_nop3", 32'(o_ins[0]), 32'hF000);
    check("t3_sq3", 32'(o_sq[0]), 32'h0);
    step(0, 0, 0, 0, 0, 16'h1357, 16'h0028);
    check("t3_res", 32'(o_ins[0]), 32'h1357);

    // Return wait
    step(0, 0, 0, 1, 0, 16'h4444, 16'h0030);
    for (int k = 0; k < 4; k++)
      step(0, 0, 0, 0, 0, 16'h4444, 16'h0030);
    step(0, 0, 0, 0, 1, 16'h4444, 16'h0030);
    check("t4_nop", 32'(o_ins[0]), 32'hF000);
    step(0, 0, 0, 0, 0, 16'h2345, 16'h0032);
    check("t4_ins", 32'(o_ins[0]), 32'h2345);
    check("t4_val", 32'(o_val[0]), 32'h1);

    // call + ret together, then PC_hazard alone
    step(0, 0, 1, 1, 0, 16'h5555, 16'h0034);
    step(0, 0, 0, 0, 0, 16'h5555, 16'h0034);
    step(0, 0, 0, 0, 0, 16'h5555, 16'h0034);
    step(0, 0, 0, 0, 0, 16'h6789, 16'h0036);
    check("t5_noret", 32'(o_val[0]), 32'h1);
    step(0, 1, 0, 0, 0, 16'h4321, 16'h0040);
    check("t5_nop", 32'(o_ins[0]), 32'hF000);
    check("t5_ct", 32'(o_ct[0]), 32'h321);

    // Saturation, then async reset in RET_WAIT
    for (int k = 0; k < 5; k++)
      step(1, 0, 0, 0, 0, 16'h0001, 16'h0050);
    check("t6_sat", 32'(st_a), 32'd3);
    step(0, 0, 0, 1, 0, 16'h0002, 16'h0052);
    check("t6_rw", 32'(o_sq[0]), 32'h1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    check("t6_sq", 32'(o_sq[0]), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 14) == 0,
           $urandom_range(0, 14) == 0,
           $urandom_range(0, 4) == 0,
           16'($urandom), 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/ifid_pipe_reg_p.md
Name: ifid_pipe_reg_p

Overview:
Parametrised next-generation IF/ID pipeline register for the 16-bit pipelined core. It sits between fetch and decode, captures the fetched instruction and PC, and presents pre-sliced decode fields. It adds three things the current stage lacks:
- explicit valid tagging;
- a configurable multi-cycle call-squash window;
- a reset-safe return-wait FSM and a saturating stall-cycle performance counter.

Parameters:
PC_W, 16, program counter width.
NOP_INSTR, 16'hF000, encoding injected on squash/flush.
CALL_BUBBLES, 1, NOP cycles inserted after a call (legal range 1..15).
PERF_W, 16, stall counter width.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
data_hazard  in  1  stall: hold stage contents
PC_hazard  in  1  flush: inject NOP
call  in  1  call detected downstream: begin call squash
ret_control  in  1  return detected: enter return wait
ret_PC  in  1  return target resolved: leave return wait
instruction_in  in  16  fetched instruction
PC_in  in  PC_W  fetched PC
instruction_out  out  16  instruction to decode/halt logic
PC_out  out  PC_W  registered PC
valid_out  out  1  instruction_out is a real instruction (not an injected NOP)
cntrl_input  out  4  field reg [15:12]
reg_rd  out  4  field reg [11:8]
branch_cond  out  3  field reg [10:8]
reg_rs  out  4  field reg [7:4]
reg_rt  out  4  field reg [3:0]
arith_imm  out  4  field reg [3:0]
load_save_imm  out  8  field reg [7:0]
call_target  out  12  field reg [11:0]
squashing  out  1  state != RUN
stall_cycles  out  PERF_W  saturating count of cycles with data_hazard=1

Behaviour:
- Async reset (rst=1): instruction_out=NOP_INSTR, PC_out=0, valid_out=0, field register=0 (so all field outputs are 0), state=RUN, bubble counter=0, stall_cycles=0. Reset mid-squash or mid-return-wait returns to RUN immediately.
- Storage: two registers.
  - Instruction register: instruction_out, valid_out.
  - Field register: a 16-bit copy of the instruction plus PC_out. All field outputs are combinational slices of it.
- Field load enable: load_en = state==RUN & !data_hazard & !call & !ret_control. When load_en=0, the field register and PC_out hold. PC_hazard alone does not block field load.
- Latency: 1 cycle from instruction_in/PC_in to outputs.
- States: RUN, CALL_SQ, RET_WAIT.
- RUN, evaluated per cycle in priority order:
  1. call: instruction_out<=NOP, valid_out<=0. If CALL_BUBBLES>1, go to CALL_SQ with cnt<=CALL_BUBBLES-1; otherwise stay in RUN.
  2. PC_hazard: instruction_out<=NOP, valid_out<=0, stay in RUN.
  3. ret_control: instruction_out<=NOP, valid_out<=0, go to RET_WAIT.
  4. data_hazard: instruction register holds.
  5. Otherwise: instruction_out<=instruction_in, valid_out<=1.
  - A simultaneous call and ret_control is resolved by call; ret_control is dropped.
- CALL_SQ:
  - instruction_out<=NOP, valid_out<=0 every cycle.
  - cnt decrements each cycle; when cnt==1, go to RUN.
  - call, ret_control, ret_PC and PC_hazard are ignored.
  - data_hazard does not freeze the counter.
- RET_WAIT:
  - instruction_out<=NOP, valid_out<=0.
  - When ret_PC=1, go to RUN. The NOP is still output in the ret_PC cycle; normal loading resumes the following cycle.
  - ret_PC in RUN or CALL_SQ is ignored.
- stall_cycles: increments on every cycle where data_hazard=1, in any state. Saturates at all-ones and never wraps.
- No X propagation: every register has a defined next value in every state.

Decomposition:
- Shared package ifid_pkg: state enum (RUN, CALL_SQ, RET_WAIT), the default NOP_INSTR constant, and field bit-position localparams (OPC_HI/LO, RD_HI/LO, RS_HI/LO, RT_HI/LO, BR_HI/LO).
- One natural sub-module: ifid_squash_fsm, which owns the state, bubble counter and load_en/inject_nop outputs. The top level holds the datapath registers and the perf counter.

Test Plan:
1. Reset, then no hazards; feed 0x1234@PC 0x0010 → next cycle: instruction_out=0x1234, PC_out=0x0010, valid_out=1, cntrl_input=1, reg_rd=2, reg_rs=3, reg_rt=4.
2. Two cycles of data_hazard with 0x5678 on input → outputs hold 0x1234 and valid_out=1; stall_cycles=2. Drop data_hazard → 0x5678 appears one cycle later.
3. CALL_BUBBLES=3; pulse call with 0xA0FF held in the field register → 3 consecutive NOP/valid_out=0 cycles, squashing=1 for 2 cycles, call_target stays 0x0FF; then normal load resumes.
4. Pulse ret_control, wait 4 cycles, pulse ret_PC → NOP for all 5 cycles through and including the ret_PC cycle; the cycle after, input 0x2345 is loaded with valid_out=1.
5. call and ret_control in the same cycle → CALL_SQ entered, RET_WAIT never entered. PC_hazard alone with data_hazard=0 → field register loads, instruction_out=NOP.
6. PERF_W=2 with 5 stall cycles → stall_cycles saturates at 3. Assert rst during RET_WAIT → all outputs return to reset values asynchronously, squashing=0.
